// File: rtl/mips_cpu_muldiv_seq_if.sv
// mips_cpu_muldiv_seq_if: decoder <-> HI/LO multiply/divide sequencer bundle.
//   master (decoder side): drives start/op/A/B, mthi/mtlo/Hi_in/Lo_in,
//                          rd_req and flush; observes the status and HI/LO.
//   slave  (sequencer)   : the reverse; drives busy, stall, done, div_zero,
//                          Hi and Lo.
interface mips_cpu_muldiv_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] Hi_in;
    logic [31:0] Lo_in;
    logic        rd_req;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output start, op, A, B, mthi, mtlo, Hi_in, Lo_in, rd_req, flush,
        input  busy, stall, done, div_zero, Hi, Lo
    );

    modport slave (
        input  start, op, A, B, mthi, mtlo, Hi_in, Lo_in, rd_req, flush,
        output busy, stall, done, div_zero, Hi, Lo
    );
endinterface

// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq: owns HI/LO and runs MULT/MULTU/DIV/DIVU iteratively
// (shift-add multiply, restoring divide, 32 iterations), then fixes signs and
// loads HI/LO in a final FIX cycle. Stalls the pipeline on any HI/LO access
// while an operation is in flight.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : slave side of mips_cpu_muldiv_seq_if
//              (issue/move/read/flush in; busy, stall, done, div_zero, Hi, Lo out)
// Optional: define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single RUN
// cycle with the * operator; divide keeps its 32-iteration path.
module mips_cpu_muldiv_seq (
    input  logic                  clk,
    input  logic                  rst,
    mips_cpu_muldiv_seq_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     a_raw_q, a_raw_d;
    logic [XLEN-1:0]     a_mag_q, a_mag_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_a_q, neg_a_d;
    logic                dz_q, dz_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic                done_q, done_d;
    logic                dzp_q, dzp_d;

    // Operand conditioning: magnitudes and signs for signed ops only
    logic            signed_op, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;

    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.A[XLEN-1];
        b_neg     = signed_op & bus.B[XLEN-1];
        a_abs     = a_neg ? (~bus.A + XLEN'(1)) : bus.A;
        b_abs     = b_neg ? (~bus.B + XLEN'(1)) : bus.B;
    end

    // Restoring divide step: acc = {remainder, dividend/quotient}
    logic [XLEN:0]     div_rem_sh;
    logic              div_ok;
    logic [XLEN-1:0]   div_rem_nx;
    logic [ACC_W-1:0]  div_step;

    always_comb begin
        div_rem_sh = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
        div_ok     = (div_rem_sh >= {1'b0, b_mag_q});
        div_rem_nx = div_ok ? XLEN'(div_rem_sh - {1'b0, b_mag_q})
                            : div_rem_sh[XLEN-1:0];
        div_step   = {div_rem_nx, acc_q[XLEN-2:0], div_ok};
    end

    // Multiply step: acc = {partial product, multiplier}, multiplier LSB first
    logic [ACC_W-1:0]  mul_next;
`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        mul_next = ACC_W'(a_mag_q) * ACC_W'(b_mag_q);
    end
`else
    logic [XLEN:0]     mul_sum;
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]}
                 + (acc_q[0] ? {1'b0, a_mag_q} : (XLEN+1)'(0));
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end
`endif

    // Sign fix-up applied in FIX
    logic [ACC_W-1:0]  prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q   ? (~acc_q[ACC_W-1:XLEN] + XLEN'(1))
                             : acc_q[ACC_W-1:XLEN];
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_raw_d   = a_raw_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dzp_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    a_raw_d   = bus.A;
                    a_mag_d   = a_abs;
                    b_mag_d   = b_abs;
                    neg_res_d = a_neg ^ b_neg;
                    neg_a_d   = a_neg;
                    dz_d      = bus.op[1] & (bus.B == '0);
                    acc_d     = {XLEN'(0), bus.op[1] ? a_abs : b_abs};
`ifdef MULDIV_FAST_MUL_EN
                    cnt_d     = bus.op[1] ? CNT_W'(31) : CNT_W'(0);
`else
                    cnt_d     = CNT_W'(31);
`endif
                    state_d   = RUN;
                end else begin
                    if (bus.mthi) hi_d = bus.Hi_in;
                    if (bus.mtlo) lo_d = bus.Lo_in;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = op_q[1] ? div_step : mul_next;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        // Divide by zero: raw dividend to HI, all-ones quotient
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dzp_d = 1'b1;
                    end else if (op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[ACC_W-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_raw_q   <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dzp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_raw_q   <= a_raw_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dzp_q     <= dzp_d;
        end
    end

    // Outputs: stall is a combinational decode for the issuing stage
    assign bus.busy     = (state_q != IDLE);
    assign bus.stall    = bus.busy & (bus.start | bus.rd_req | bus.mthi | bus.mtlo);
    assign bus.done     = done_q;
    assign bus.div_zero = dzp_q;
    assign bus.Hi       = hi_q;
    assign bus.Lo       = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb_mips_cpu_muldiv_seq: directed vectors with a result scoreboard. Stimulus
// pushes the expected HI/LO/div_zero of each operation; a monitor pops and
// compares on every done pulse. Timing/stall/flush/reset checks are inline.
module tb_mips_cpu_muldiv_seq;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY   = 2;
    localparam int FLUSH_WAIT = 0;
`else
    localparam int MUL_BUSY   = 33;
    localparam int FLUSH_WAIT = 3;
`endif
    localparam int DIV_BUSY = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_cpu_muldiv_seq_if bus();

    mips_cpu_muldiv_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_hi", bus.Hi, e.hi);
                check("result_lo", bus.Lo, e.lo);
                check("result_div_zero", 32'(bus.div_zero), 32'(e.dz));
            end
        end else if (rst === 1'b0 && bus.div_zero === 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL div_zero_without_done: got div_zero=1 expected 0");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.Hi_in = '0; bus.Lo_in = '0;
        bus.rd_req = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        @(posedge clk); #1;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.Hi_in = h; bus.Lo_in = l;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        @(negedge clk);
        check("mthi_value", bus.Hi, h);
        check("mtlo_value", bus.Lo, l);
    endtask

    // Issue one operation, count busy cycles until done
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic dz, input int exp_busy);
        int nb;
        bit seen;
        nb = 0;
        seen = 1'b0;
        sb_q.push_back('{hi: hi, lo: lo, dz: dz});
        issue(op, a, b);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) nb++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    initial begin
        bit stall_ok, hold_ok, seen;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hi", bus.Hi, 32'h0);
        check("reset_lo", bus.Lo, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_div_zero", 32'(bus.div_zero), 32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        set_hilo(32'h12345678, 32'h9ABCDEF0);

        run_op("mult_neg2_x3", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MUL_BUSY);
        run_op("mult_neg3_xneg5", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'hF, 1'b0, MUL_BUSY);
        run_op("multu_max_sq", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, MUL_BUSY);
        run_op("div_neg7_by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_BUSY);
        run_op("div_7_byneg2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, DIV_BUSY);
        run_op("divu_7_by0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1, DIV_BUSY);
        run_op("div_neg7_by0", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, DIV_BUSY);
        run_op("div_min_byneg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, DIV_BUSY);

        // HI/LO access while busy: stalled, old values held, move replayed after done
        set_hilo(32'h11111111, 32'h22222222);
        sb_q.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (8) @(posedge clk);
        #1;
        bus.rd_req = 1'b1; bus.mthi = 1'b1; bus.Hi_in = 32'hABCD0123;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            if (bus.Hi !== 32'h11111111 || bus.Lo !== 32'h22222222) hold_ok = 1'b0;
        end
        check("stall_done_seen", 32'(seen), 32'd1);
        check("stall_held_while_busy", 32'(stall_ok), 32'd1);
        check("hilo_held_while_busy", 32'(hold_ok), 32'd1);
        check("stall_in_done_cycle", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.rd_req = 1'b0; bus.mthi = 1'b0;
        @(negedge clk);
        check("mthi_replayed_hi", bus.Hi, 32'hABCD0123);
        check("mthi_replayed_lo", bus.Lo, 32'd14);

        // Flush mid-operation: no done, HI/LO untouched, immediate restart
        set_hilo(32'hAAAA0000, 32'hBBBB0000);
        issue(OP_MULT, 32'd5, 32'd6);
        repeat (FLUSH_WAIT) @(posedge clk);
        if (FLUSH_WAIT > 0) #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_hi", bus.Hi, 32'hAAAA0000);
        check("flush_lo", bus.Lo, 32'hBBBB0000);
        run_op("multu_after_flush", OP_MULTU, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, MUL_BUSY);

        // Asynchronous reset in the middle of a divide
        issue(OP_DIV, 32'hFFFFFF9C, 32'd3);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hi", bus.Hi, 32'h0);
        check("midrst_lo", bus.Lo, 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        run_op("div_neg100_by3", OP_DIV, 32'hFFFFFF9C, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFDF, 1'b0, DIV_BUSY);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_cpu_muldiv_seq.md
# mips_cpu_muldiv_seq

Multi-cycle sequencer owning the HI/LO special registers and the MULT/MULTU/DIV/DIVU datapath of the MIPS core. It sits beside the ALU:
- the decoder issues a multiply/divide or MTHI/MTLO;
- the sequencer runs an iterative shift-add multiply or restoring divide over 32 cycles;
- it writes HI/LO on completion and stalls the pipeline on any HI/LO access while an operation is in flight.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue a multiply/divide this cycle.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  32  rs operand: multiplicand or dividend.
- B  in  32  rt operand: multiplier or divisor.
- mthi  in  1  write Hi_in to HI.
- mtlo  in  1  write Lo_in to LO.
- Hi_in  in  32  MTHI data.
- Lo_in  in  32  MTLO data.
- rd_req  in  1  MFHI/MFLO in decode this cycle.
- flush  in  1  abort the in-flight operation.
- busy  out  1  operation in flight.
- stall  out  1  freeze the issuing pipeline stage (combinational).
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- div_zero  out  1  pulses with done when a DIV/DIVU had B==0.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 latches op, |A| and |B| (magnitudes for signed ops; raw values for unsigned), and result signs. Then counter<=31, goes to RUN.
  - Without start, mthi/mtlo update HI/LO at the edge; both may be asserted together.
  - start has priority over mthi/mtlo in the same cycle; the move is dropped.
- RUN, one iteration per cycle:
  - Multiply: shift-add on a 64-bit product accumulator, multiplier LSB first.
  - Divide: restoring; shift the remainder left and bring in the next dividend MSB. Trial-subtract the divisor; the quotient bit = no borrow.
  - Counter decrements; goes to FIX when counter==0.
- FIX:
  - Applies signs. Product is negated if sign(A)!=sign(B). Quotient is negated if sign(A)!=sign(B). Remainder takes the sign of A.
  - Loads HI (product[63:32] / remainder) and LO (product[31:0] / quotient). Pulses done; returns to IDLE.
- Divide by zero (B==0), all ops: LO=32'hFFFFFFFF, HI=A (original, unmodified); div_zero=1 with done. No sign fix applied.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0 (wraps, no trap).
- Output equations:
  - busy = (state!=IDLE).
  - stall = busy & (start | rd_req | mthi | mtlo).
- While busy:
  - start, mthi and mtlo are not accepted. The pipeline holds them via stall and re-presents them.
  - Hi/Lo outputs show the old values.
- flush: in RUN or FIX, goes to IDLE next edge. HI/LO are unchanged and done/div_zero are not pulsed. In IDLE, flush has no effect and does not block start.
- Reset (any time, including mid-operation): state=IDLE, Hi=0, Lo=0, busy=0, done=0, div_zero=0, counter=0. stall is therefore 0.

## Timing
- Edge E0 samples start.
- RUN spans E1..E32 (32 iterations).
- E33 (FIX) writes HI/LO and raises done/div_zero for the cycle after E33.
- busy is high from after E0 through the cycle before E33, i.e. 33 cycles.
- A new start is accepted in the same cycle done is high (state is IDLE again).
- mthi/mtlo in IDLE have 1-cycle latency: Hi/Lo are visible the cycle after the edge.
- rd_req in the cycle done is high is not stalled and sees the new HI/LO.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full 64-bit product with the * operator in one RUN cycle: counter is loaded with 0, FIX at E2, done after E2.
  - Divide is unchanged at 32 iterations.
- Undefined: multiply uses the 32-cycle shift-add path and timing above.

## Test plan
- MULT A=32'hFFFFFFFE (-2), B=3 -> done after E33; HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; busy high for 33 cycles.
- DIV A=32'hFFFFFFF9 (-7), B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIVU A=7, B=0 -> LO=32'hFFFFFFFF, HI=7, div_zero pulses with done.
- MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=1. With MULDIV_FAST_MUL_EN: same values, done after E2.
- Start DIVU, then at cycle 10 assert rd_req and mthi -> stall=1 until done; HI/LO hold old values until E33. mthi, re-presented after done, then overwrites HI.
- Start MULT, flush at cycle 5 -> busy=0 next cycle, HI/LO unchanged, no done. A new start is accepted immediately.
- Assert rst at cycle 20 of a DIV -> Hi=Lo=0, busy=0, done never pulses. start two cycles after rst release runs normally.
